// File: rtl/adc_unsign_to_sign_capture_if.sv
// ---------------------------------------------------------------------------
// AdcUnsignToSignCaptureIf
// Purpose : bundles the ADC sample strobe and the valid/ready result stream
//           of adc_unsign_to_sign_capture into one port.
// Signals :
//   adc_data  [N-1:0] offset-binary sample from the ADC
//   adc_valid         sample strobe (no back-pressure on the ADC side)
//   out_data  [N-1:0] two's-complement result at the FIFO head
//   out_valid         FIFO head is valid
//   out_ready         consumer accepts the head this cycle
// Modports:
//   master - sample producer and result consumer (e.g. a testbench)
//   slave  - the capture block itself
// ---------------------------------------------------------------------------
interface adc_unsign_to_sign_capture_if #(
    parameter int N = 14
);
    logic [N-1:0] adc_data;
    logic         adc_valid;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output adc_data,
        output adc_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  adc_data,
        input  adc_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/adc_unsign_to_sign_capture.sv
// ---------------------------------------------------------------------------
// adc_unsign_to_sign_capture
// Purpose : captures offset-binary ADC samples, converts them to two's
//           complement, optionally boxcar-averages 2^DEC_LOG2 of them, and
//           hands results to the IQ mixers through a 2-entry FWFT FIFO.
//           The ADC cannot be stalled: a result that finds the FIFO full
//           (with no read in the same cycle) is dropped and flagged.
// Parameters:
//   N         sample width in and out (>= 2)
//   DEC_LOG2  decimation exponent, 0 = pass-through, 1..8 = average
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   bus         slave side of adc_unsign_to_sign_capture_if
//                 (adc_data/adc_valid in, out_data/out_valid out, out_ready in)
//   i_ovf_clr   clears the sticky overflow flag
//   o_ovf       sticky flag: at least one result was dropped
//   o_smp_cnt   results successfully written to the FIFO, wraps at 16 bits
// Build option:
//   SYM_CLAMP_EN  when defined, offset-binary 0 maps to -(2^(N-1)-1) instead
//                 of -2^(N-1), giving a symmetric range before averaging.
// ---------------------------------------------------------------------------
module adc_unsign_to_sign_capture #(
    parameter int N        = 14,
    parameter int DEC_LOG2 = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    adc_unsign_to_sign_capture_if.slave  bus,
    input  logic                         i_ovf_clr,
    output logic                         o_ovf,
    output logic [15:0]                  o_smp_cnt
);

    // Offset-binary to two's complement is just an MSB flip.
    logic [N-1:0] w_conv;
    logic [N-1:0] r_conv;
    logic         r_convValid;

    // Stage 1 combinational conversion; the optional clamp folds the single
    // asymmetric code onto the symmetric minimum before it reaches the adder.
    always_comb begin
        w_conv = {~bus.adc_data[N-1], bus.adc_data[N-2:0]};
`ifdef SYM_CLAMP_EN
        if (bus.adc_data == '0) begin
            w_conv = {1'b1, {(N-1){1'b0}}} | {{(N-1){1'b0}}, 1'b1};
        end
`endif
    end

    // Stage 1 register: one sample per clock, no stall path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conv      <= '0;
            r_convValid <= 1'b0;
        end else begin
            r_conv      <= w_conv;
            r_convValid <= bus.adc_valid;
        end
    end

    // Stage 2 produces a write request plus the value to push.
    logic         w_wrReq;
    logic [N-1:0] w_result;

    generate
        if (DEC_LOG2 == 0) begin : g_pass
            assign w_wrReq  = r_convValid;
            assign w_result = r_conv;
        end else begin : g_dec
            localparam int AW = N + DEC_LOG2;

            logic signed [AW-1:0]       r_acc;
            logic        [DEC_LOG2-1:0] r_phase;
            logic signed [AW-1:0]       w_convExt;
            logic signed [AW-1:0]       w_sum;

            assign w_convExt = {{DEC_LOG2{r_conv[N-1]}}, r_conv};
            assign w_sum     = r_acc + w_convExt;
            assign w_wrReq   = r_convValid && (r_phase == '1);
            // Dropping the low bits of a two's-complement sum is an
            // arithmetic shift, i.e. floor toward -inf; the mean of N-bit
            // values always fits back into N bits.
            assign w_result  = w_sum[AW-1:DEC_LOG2];

            // Accumulator restarts on phase 0; the phase only advances on
            // valid samples so gaps in adc_valid simply pause the average.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_acc   <= '0;
                    r_phase <= '0;
                end else if (r_convValid) begin
                    r_acc   <= (r_phase == '0) ? w_convExt : w_sum;
                    r_phase <= r_phase + DEC_LOG2'(1);
                end
            end
        end
    endgenerate

    // Two-entry first-word-fall-through FIFO.
    logic [N-1:0] r_mem [2];
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_count;
    logic         r_ovf;
    logic [15:0]  r_smpCnt;

    logic w_full;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    // A read frees a slot in the same cycle, so a full FIFO can still take
    // a write when the consumer is popping; otherwise the result is lost.
    always_comb begin
        w_full = (r_count == 2'd2);
        w_rd   = (r_count != 2'd0) && bus.out_ready;
        w_wr   = w_wrReq && (!w_full || w_rd);
        w_drop = w_wrReq && w_full && !w_rd;
    end

    // FIFO storage, pointers, overflow flag and write counter. Setting the
    // overflow flag wins over a simultaneous clear so no drop goes unseen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
            r_ovf    <= 1'b0;
            r_smpCnt <= 16'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wrPtr] <= w_result;
                r_wrPtr        <= ~r_wrPtr;
                r_smpCnt       <= r_smpCnt + 16'd1;
            end
            if (w_rd) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_mem[r_rdPtr];
    assign bus.out_valid = (r_count != 2'd0);
    assign o_ovf         = r_ovf;
    assign o_smp_cnt     = r_smpCnt;

endmodule

// File: tb/tb_adc_unsign_to_sign_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_unsign_to_sign_capture
// Purpose : drives a pass-through instance (DEC_LOG2=0) and a decimating
//           instance (DEC_LOG2=2) with identical stimulus and compares both
//           against a behavioural model: signed value = code - 2^(N-1),
//           mean of every 4 valid samples rounded down, and a 2-deep queue
//           that drops a result when it is full and nothing leaves.
// ---------------------------------------------------------------------------
module tb_adc_unsign_to_sign_capture;

    localparam int N    = 14;
    localparam int HALF = 8192;

    logic        clk;
    logic        rst;
    logic        ovfClr;
    logic        ovfP, ovfD;
    logic [15:0] cntP, cntD;

    adc_unsign_to_sign_capture_if #(.N(N)) busP ();
    adc_unsign_to_sign_capture_if #(.N(N)) busD ();

    adc_unsign_to_sign_capture #(.N(N), .DEC_LOG2(0)) dutP (
        .i_clk(clk), .i_rst(rst), .bus(busP.slave),
        .i_ovf_clr(ovfClr), .o_ovf(ovfP), .o_smp_cnt(cntP)
    );

    adc_unsign_to_sign_capture #(.N(N), .DEC_LOG2(2)) dutD (
        .i_clk(clk), .i_rst(rst), .bus(busD.slave),
        .i_ovf_clr(ovfClr), .o_ovf(ovfD), .o_smp_cnt(cntD)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nVec  = 0;
    int nFail = 0;

    // Reference model state: index 0 = pass-through, 1 = average of 4.
    int   mq   [2][2];
    int   msz  [2];
    logic movf [2];
    int   mcnt [2];
    logic mpv  [2];
    int   mpd  [2];
    int   dsum;
    int   dn;

    function automatic int convRef(input int d);
`ifdef SYM_CLAMP_EN
        if (d == 0) return -(HALF - 1);
`endif
        return d - HALF;
    endfunction

    function automatic int floorDiv4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    function automatic logic obsValid(input int k);
        return (k == 0) ? busP.out_valid : busD.out_valid;
    endfunction

    function automatic logic [N-1:0] obsData(input int k);
        return (k == 0) ? busP.out_data : busD.out_data;
    endfunction

    function automatic logic obsOvf(input int k);
        return (k == 0) ? ovfP : ovfD;
    endfunction

    function automatic logic [15:0] obsCnt(input int k);
        return (k == 0) ? cntP : cntD;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 2; k++) begin
            msz[k]  = 0;
            movf[k] = 1'b0;
            mcnt[k] = 0;
            mpv[k]  = 1'b0;
            mpd[k]  = 0;
        end
        dsum = 0;
        dn   = 0;
    endtask

    task automatic doReset();
        rst            = 1'b1;
        busP.adc_valid = 1'b0;
        busD.adc_valid = 1'b0;
        ovfClr         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear();
    endtask

    // Drives one cycle of inputs to both DUTs, advances the model across the
    // coming clock edge, then waits until just after that edge.
    task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                                 input logic rdy, input logic clr);
        int c;
        busP.adc_valid = v;  busD.adc_valid = v;
        busP.adc_data  = d;  busD.adc_data  = d;
        busP.out_ready = rdy; busD.out_ready = rdy;
        ovfClr = clr;
        c = convRef(int'(d));
        for (int k = 0; k < 2; k++) begin
            logic drop;
            if (msz[k] > 0 && rdy) begin
                mq[k][0] = mq[k][1];
                msz[k]--;
            end
            drop = mpv[k] && (msz[k] == 2);
            if (mpv[k] && !drop) begin
                mq[k][msz[k]] = mpd[k];
                msz[k]++;
                mcnt[k] = (mcnt[k] + 1) % 65536;
            end
            if (drop) movf[k] = 1'b1;
            else if (clr) movf[k] = 1'b0;
        end
        mpv[0] = v;
        mpd[0] = c;
        mpv[1] = 1'b0;
        if (v) begin
            dsum += c;
            dn++;
            if (dn == 4) begin
                mpv[1] = 1'b1;
                mpd[1] = floorDiv4(dsum);
                dsum   = 0;
                dn     = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        doReset();
        for (int k = 0; k < 2; k++) begin
            nVec++;
            if (obsValid(k) !== 1'b0) begin
                nFail++; $display("[TB] FAIL reset_valid dut%0d: got %0b want 0", k, obsValid(k));
            end
            nVec++;
            if (obsData(k) !== '0) begin
                nFail++; $display("[TB] FAIL reset_data dut%0d: got %h want 0000", k, obsData(k));
            end
            nVec++;
            if (obsOvf(k) !== 1'b0) begin
                nFail++; $display("[TB] FAIL reset_ovf dut%0d: got %0b want 0", k, obsOvf(k));
            end
            nVec++;
            if (obsCnt(k) !== 16'd0) begin
                nFail++; $display("[TB] FAIL reset_cnt dut%0d: got %0d want 0", k, obsCnt(k));
            end
        end
    endtask

    task automatic test_passthrough();
        logic [N-1:0] ins  [3];
        logic [N-1:0] outs [3];
        ins  = '{14'h2000, 14'h3FFF, 14'h0001};
        outs = '{14'h0000, 14'h1FFF, 14'h2001};
        doReset();
        for (int t = 0; t < 6; t++) begin
            applyStimulus(t < 3, (t < 3) ? ins[t] : 14'h0, 1'b1, 1'b0);
            if (t >= 1 && t <= 3) begin
                nVec++;
                if (busP.out_valid !== 1'b1 || busP.out_data !== outs[t-1]) begin
                    nFail++;
                    $display("[TB] FAIL pass_latency t%0d: got v=%0b %h want v=1 %h",
                             t, busP.out_valid, busP.out_data, outs[t-1]);
                end
            end
            nVec++;
            if (busP.out_valid !== (msz[0] > 0)) begin
                nFail++; $display("[TB] FAIL pass_valid t%0d: got %0b want %0b", t, busP.out_valid, msz[0] > 0);
            end
        end
        nVec++;
        if (cntP !== 16'd3) begin
            nFail++; $display("[TB] FAIL pass_cnt: got %0d want 3", cntP);
        end
    endtask

    task automatic test_min_code();
        logic [N-1:0] expMin;
`ifdef SYM_CLAMP_EN
        expMin = 14'h2001;
`else
        expMin = 14'h2000;
`endif
        doReset();
        applyStimulus(1'b1, 14'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
        nVec++;
        if (busP.out_valid !== 1'b1 || busP.out_data !== expMin) begin
            nFail++;
            $display("[TB] FAIL min_code: got v=%0b %h want v=1 %h", busP.out_valid, busP.out_data, expMin);
        end
    endtask

    task automatic test_decimate();
        logic [N-1:0] ins [4];
        ins = '{14'h2004, 14'h2008, 14'h200C, 14'h2010};
        doReset();
        for (int t = 0; t < 4; t++) applyStimulus(1'b1, ins[t], 1'b1, 1'b0);
        applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
        nVec++;
        if (busD.out_valid !== 1'b1 || busD.out_data !== 14'h000A || cntD !== 16'd1) begin
            nFail++;
            $display("[TB] FAIL dec_mean: got v=%0b %h cnt=%0d want v=1 000a cnt=1",
                     busD.out_valid, busD.out_data, cntD);
        end
        applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) applyStimulus(1'b1, 14'h1FFF, 1'b1, 1'b0);
        applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
        nVec++;
        if (busD.out_valid !== 1'b1 || busD.out_data !== 14'h3FFF) begin
            nFail++;
            $display("[TB] FAIL dec_floor: got v=%0b %h want v=1 3fff", busD.out_valid, busD.out_data);
        end
    endtask

    task automatic test_overflow();
        doReset();
        for (int t = 1; t <= 3; t++) applyStimulus(1'b1, 14'(HALF + t), 1'b0, 1'b0);
        applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
        nVec++;
        if (ovfP !== 1'b1 || cntP !== 16'd2) begin
            nFail++; $display("[TB] FAIL ovf_set: got ovf=%0b cnt=%0d want ovf=1 cnt=2", ovfP, cntP);
        end
        for (int t = 1; t <= 3; t++) begin
            nVec++;
            if (busP.out_valid !== (t <= 2) || (t <= 2 && busP.out_data !== 14'(t))) begin
                nFail++;
                $display("[TB] FAIL ovf_drain%0d: got v=%0b %h want v=%0b %h",
                         t, busP.out_valid, busP.out_data, t <= 2, 14'(t));
            end
            applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 14'h0, 1'b1, 1'b1);
        nVec++;
        if (ovfP !== 1'b0) begin
            nFail++; $display("[TB] FAIL ovf_clr: got %0b want 0", ovfP);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(1'b1, 14'(HALF + 11), 1'b0, 1'b0);
        applyStimulus(1'b1, 14'(HALF + 12), 1'b0, 1'b0);
        applyStimulus(1'b1, 14'(HALF + 13), 1'b0, 1'b0);
        applyStimulus(1'b1, 14'(HALF + 14), 1'b1, 1'b0);
        nVec++;
        if (ovfP !== 1'b0 || busP.out_data !== 14'd12 || cntP !== 16'd3) begin
            nFail++;
            $display("[TB] FAIL b2b_full_rw: got ovf=%0b %h cnt=%0d want ovf=0 000c cnt=3",
                     ovfP, busP.out_data, cntP);
        end
        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
            nVec++;
            if (busP.out_valid !== (msz[0] > 0) || (msz[0] > 0 && busP.out_data !== 14'(mq[0][0]))) begin
                nFail++;
                $display("[TB] FAIL b2b_order t%0d: got v=%0b %h want v=%0b %h",
                         t, busP.out_valid, busP.out_data, msz[0] > 0, 14'(mq[0][0]));
            end
        end
        nVec++;
        if (ovfP !== 1'b0 || cntP !== 16'd4) begin
            nFail++; $display("[TB] FAIL b2b_cnt: got ovf=%0b cnt=%0d want ovf=0 cnt=4", ovfP, cntP);
        end
    endtask

    task automatic test_reset_midstream();
        doReset();
        applyStimulus(1'b1, 14'h3000, 1'b1, 1'b0);
        applyStimulus(1'b1, 14'h3000, 1'b1, 1'b0);
        doReset();
        nVec++;
        if (busD.out_valid !== 1'b0 || busD.out_data !== '0 || ovfD !== 1'b0 || cntD !== 16'd0) begin
            nFail++;
            $display("[TB] FAIL mid_reset: got v=%0b %h ovf=%0b cnt=%0d want all 0",
                     busD.out_valid, busD.out_data, ovfD, cntD);
        end
        applyStimulus(1'b1, 14'h2001, 1'b1, 1'b0);
        applyStimulus(1'b1, 14'h2002, 1'b1, 1'b0);
        applyStimulus(1'b1, 14'h2003, 1'b1, 1'b0);
        applyStimulus(1'b1, 14'h2006, 1'b1, 1'b0);
        applyStimulus(1'b0, 14'h0, 1'b1, 1'b0);
        nVec++;
        if (busD.out_valid !== 1'b1 || busD.out_data !== 14'd3 || cntD !== 16'd1) begin
            nFail++;
            $display("[TB] FAIL mid_clean: got v=%0b %h cnt=%0d want v=1 0003 cnt=1",
                     busD.out_valid, busD.out_data, cntD);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int t = 0; t < 600; t++) begin
            applyStimulus($urandom_range(0, 9) < 7, 14'($urandom_range(0, 16383)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                nVec++;
                if (obsValid(k) !== (msz[k] > 0)) begin
                    nFail++; $display("[TB] FAIL rand_valid t%0d dut%0d: got %0b want %0b", t, k, obsValid(k), msz[k] > 0);
                end
                if (msz[k] > 0) begin
                    nVec++;
                    if (obsData(k) !== 14'(mq[k][0])) begin
                        nFail++; $display("[TB] FAIL rand_data t%0d dut%0d: got %h want %h", t, k, obsData(k), 14'(mq[k][0]));
                    end
                end
                nVec++;
                if (obsOvf(k) !== movf[k]) begin
                    nFail++; $display("[TB] FAIL rand_ovf t%0d dut%0d: got %0b want %0b", t, k, obsOvf(k), movf[k]);
                end
                nVec++;
                if (obsCnt(k) !== 16'(mcnt[k])) begin
                    nFail++; $display("[TB] FAIL rand_cnt t%0d dut%0d: got %0d want %0d", t, k, obsCnt(k), mcnt[k]);
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        ovfClr         = 1'b0;
        busP.adc_data  = '0; busD.adc_data  = '0;
        busP.adc_valid = 1'b0; busD.adc_valid = 1'b0;
        busP.out_ready = 1'b0; busD.out_ready = 1'b0;
        modelClear();
        test_reset();
        test_passthrough();
        test_min_code();
        test_decimate();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
